// File: rtl/boid_pkg.sv
// -----------------------------------------------------------------------------
// boid_pkg
// Shared definitions for the boid rasteriser and the VGA read path:
//   - default screen resolution
//   - boid coordinate widths (x: 10 bits, y: 9 bits)
//   - sprite size limits and the sprite offset counter width
//   - frame-writer FSM state encoding
// -----------------------------------------------------------------------------
package boid_pkg;

    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;

    localparam int X_W        = 10;
    localparam int Y_W        = 9;

    localparam int SPRITE_MIN = 1;
    localparam int SPRITE_MAX = 4;
    // Width of the dx/dy offset counters; covers 0..SPRITE_MAX-1.
    localparam int D_W        = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWAP,
        ST_FETCH,
        ST_PLOT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/boid_xy_to_addr.sv
// -----------------------------------------------------------------------------
// boid_xy_to_addr
// Combinational pixel coordinate -> linear frame-buffer address.
// Shared by the frame writer and the VGA read path.
// Ports:
//   x         in   X_IN_W   pixel column (may exceed the screen)
//   y         in   Y_IN_W   pixel row    (may exceed the screen)
//   addr      out  ADDR_W   y*H_RES + x, full width, never truncated
//   on_screen out  1        x < H_RES and y < V_RES
// -----------------------------------------------------------------------------
module boid_xy_to_addr #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int X_IN_W = 11,
    parameter int Y_IN_W = 10,
    parameter int ADDR_W = $clog2(H_RES*V_RES)+1
) (
    input  logic [X_IN_W-1:0] x,
    input  logic [Y_IN_W-1:0] y,
    output logic [ADDR_W-1:0] addr,
    output logic              on_screen
);

    localparam logic [X_IN_W-1:0] X_LIM = X_IN_W'(H_RES);
    localparam logic [Y_IN_W-1:0] Y_LIM = Y_IN_W'(V_RES);

    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;

    assign x_ext = ADDR_W'(x);
    assign y_ext = ADDR_W'(y);

    generate
        if (H_RES == 640) begin : g_mul640
            // 640 = 512 + 128: two shifts and an add instead of a multiplier.
            assign addr = (y_ext << 9) + (y_ext << 7) + x_ext;
        end else begin : g_mul_generic
            assign addr = y_ext * ADDR_W'(H_RES) + x_ext;
        end
    endgenerate

    assign on_screen = (x < X_LIM) && (y < Y_LIM);

endmodule

// File: rtl/boid_frame_writer.sv
// -----------------------------------------------------------------------------
// boid_frame_writer
// Per-frame sequencer: on each frame_end pulse, requests a buffer swap/clear,
// walks every boid channel, plots an SPRITE x SPRITE square per boid into the
// 1-bit display buffer and then pulses done.
// Every pixel slot costs one cycle whether or not it is clipped, so a frame
// takes 2 + boids*(1+SPRITE^2) cycles from SWAP through DONE.
//
// Optional build macro: BOID_ENABLE_MASK_EN adds input boid_mask, sampled in
// SWAP; boids whose bit is 0 are skipped with no FETCH/PLOT cycles.
//
// Ports:
//   clock      in   1        system clock
//   resetn     in   1        asynchronous active-low reset
//   frame_end  in   1        one-cycle pulse at end of visible frame
//   boid_mask  in   NUM_BOIDS  per-boid enable (BOID_ENABLE_MASK_EN only)
//   boid_sel   out  SEL_W    boid whose coordinates are requested
//   x_in       in   10       x of selected boid (combinational from boid_sel)
//   y_in       in   9        y of selected boid (combinational from boid_sel)
//   buf_swap   out  1        one-cycle pulse: switch to cleared buffer
//   wr_en      out  1        pixel write strobe
//   wr_addr    out  ADDR_W   pixel address y*H_RES + x
//   wr_data    out  1        pixel value (1 whenever wr_en)
//   busy       out  1        high from accepted frame_end through DONE
//   done       out  1        one-cycle pulse, frame fully plotted
//   overruns   out  8        saturating count of frame_end ignored while busy
// -----------------------------------------------------------------------------
module boid_frame_writer
    import boid_pkg::*;
#(
    parameter int NUM_BOIDS = 8,
    parameter int H_RES     = H_RES_DEF,
    parameter int V_RES     = V_RES_DEF,
    parameter int SPRITE    = 1,
    parameter int ADDR_W    = $clog2(H_RES*V_RES)+1,
    parameter int SEL_W     = $clog2(NUM_BOIDS)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 frame_end,
`ifdef BOID_ENABLE_MASK_EN
    input  logic [NUM_BOIDS-1:0] boid_mask,
`endif
    output logic [SEL_W-1:0]     boid_sel,
    input  logic [X_W-1:0]       x_in,
    input  logic [Y_W-1:0]       y_in,
    output logic                 buf_swap,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           overruns
);

    localparam logic [D_W-1:0] D_LAST = D_W'(SPRITE - 1);

    state_t                state_reg;
    logic [SEL_W-1:0]      idx_reg;
    logic [X_W-1:0]        bx_reg;
    logic [Y_W-1:0]        by_reg;
    logic [D_W-1:0]        dx_reg;
    logic [D_W-1:0]        dy_reg;
    logic [NUM_BOIDS-1:0]  mask_reg;
    logic                  buf_swap_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [7:0]            overruns_reg;

    logic [NUM_BOIDS-1:0]  mask_in;
    logic [SEL_W-1:0]      first_idx;
    logic [SEL_W-1:0]      next_idx;
    logic                  has_next;
    logic [X_W:0]          px;
    logic [Y_W:0]          py;
    logic [ADDR_W-1:0]     pix_addr;
    logic                  pix_on_screen;

`ifdef BOID_ENABLE_MASK_EN
    assign mask_in = boid_mask;
`else
    assign mask_in = '1;
`endif

    // Lowest enabled boid for the start of a frame.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_BOIDS - 1; i >= 0; i--) begin
            if (mask_in[i]) begin
                first_idx = SEL_W'(i);
            end
        end
    end

    // Lowest enabled boid strictly above the current one.
    always_comb begin
        has_next = 1'b0;
        next_idx = idx_reg;
        for (int i = NUM_BOIDS - 1; i >= 0; i--) begin
            if ((i > int'(idx_reg)) && mask_reg[i]) begin
                has_next = 1'b1;
                next_idx = SEL_W'(i);
            end
        end
    end

    // One extra bit so bx+dx / by+dy near the coordinate limit cannot wrap
    // back onto the screen.
    assign px = (X_W+1)'(bx_reg) + (X_W+1)'(dx_reg);
    assign py = (Y_W+1)'(by_reg) + (Y_W+1)'(dy_reg);

    boid_xy_to_addr #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .X_IN_W (X_W + 1),
        .Y_IN_W (Y_W + 1),
        .ADDR_W (ADDR_W)
    ) u_xy_to_addr (
        .x         (px),
        .y         (py),
        .addr      (pix_addr),
        .on_screen (pix_on_screen)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            bx_reg       <= '0;
            by_reg       <= '0;
            dx_reg       <= '0;
            dy_reg       <= '0;
            mask_reg     <= '0;
            buf_swap_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overruns_reg <= '0;
        end else begin
            buf_swap_reg <= 1'b0;
            done_reg     <= 1'b0;

            // Any pulse seen outside IDLE (including the DONE cycle) is dropped.
            if (frame_end && (state_reg != ST_IDLE) && (overruns_reg != 8'hFF)) begin
                overruns_reg <= overruns_reg + 8'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (frame_end) begin
                        state_reg    <= ST_SWAP;
                        buf_swap_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        idx_reg      <= '0;
                    end
                end
                ST_SWAP: begin
                    mask_reg <= mask_in;
                    if (mask_in == '0) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        idx_reg   <= first_idx;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    bx_reg    <= x_in;
                    by_reg    <= y_in;
                    dx_reg    <= '0;
                    dy_reg    <= '0;
                    state_reg <= ST_PLOT;
                end
                ST_PLOT: begin
                    if (dx_reg == D_LAST) begin
                        dx_reg <= '0;
                        if (dy_reg == D_LAST) begin
                            if (has_next) begin
                                idx_reg   <= next_idx;
                                state_reg <= ST_FETCH;
                            end else begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            dy_reg <= dy_reg + 1'b1;
                        end
                    end else begin
                        dx_reg <= dx_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    idx_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Write strobe is decoded from registered state and coordinates only.
    assign wr_en    = (state_reg == ST_PLOT) && pix_on_screen;
    assign wr_addr  = wr_en ? pix_addr : '0;
    assign wr_data  = wr_en;

    assign boid_sel = idx_reg;
    assign buf_swap = buf_swap_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign overruns = overruns_reg;

endmodule
